// File: rtl/pixel_phrase_builder.sv
// pixel_phrase_builder
// Packs RGB565 camera pixels into 128-bit phrases of eight pixels and
// queues completed phrases in a small FIFO that feeds an AXI-Stream master.
// Pixels are discarded until a frame-start (tuser) pixel has been seen.
// When the FIFO is full and not draining, new phrases are dropped and
// counted.
//
// state | meaning
// ------+----------------------------------------------------------
// SYNC  | waiting for a frame-start pixel; every other pixel is discarded
// PACK  | accumulating pixels into the current phrase at the slot counter

module pixel_phrase_builder #(
  parameter int BUF_DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [15:0]                pixel_data_in,
  input  logic                       pixel_valid_in,
  input  logic                       pixel_tuser_in,
  output logic [127:0]               phrase_axis_data,
  output logic                       phrase_axis_tuser,
  output logic                       phrase_axis_valid,
  input  logic                       phrase_axis_ready,
  input  logic                       clear_in,
  output logic                       overflow_out,
  output logic [15:0]                drop_count_out,
  output logic [$clog2(BUF_DEPTH):0] buf_level_out
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int LW = PW + 1;

  // Reject depths the pointer arithmetic cannot support.
  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pixel_phrase_builder: BUF_DEPTH must be a power of two >= 2");
  end

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_PACK = 1'b1
  } state_t;

  // Release of the async reset is retimed by one flop; pixel intake is held
  // off until it is set, so the first pixel accepted is the one on the second
  // rising edge after release.
  logic run_q, run_d;

  state_t         state_q, state_d;
  logic [2:0]     slot_q, slot_d;
  logic [111:0]   part_q, part_d;      // slots 0..6; slot 7 goes straight to the FIFO
  logic           first_q, first_d;    // current phrase carries the frame-start pixel

  logic [127:0]   mem_q    [BUF_DEPTH];
  logic [127:0]   mem_d    [BUF_DEPTH];
  logic           mem_tu_q [BUF_DEPTH];
  logic           mem_tu_d [BUF_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;

  logic           ovf_q, ovf_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;

  logic           accept;
  logic           push;
  logic [127:0]   push_data;
  logic           push_tu;
  logic           pop;
  logic           full;
  logic           drop;
  logic           wr_en;

  assign accept = run_q & pixel_valid_in;

  // Reset-release retiming flop.
  always_comb begin
    run_d = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: only a frame-start pixel moves SYNC to PACK; PACK is
  // left only through reset.
  always_comb begin
    state_d = state_q;
    if (accept && pixel_tuser_in) begin
      state_d = ST_PACK;
    end
  end

  // FSM outputs: slot placement, phrase completion and frame-start tagging.
  always_comb begin
    slot_d    = slot_q;
    part_d    = part_q;
    first_d   = first_q;
    push      = 1'b0;
    push_data = {pixel_data_in, part_q};
    push_tu   = first_q;
    if (accept) begin
      if (pixel_tuser_in) begin
        // A frame start abandons any partial phrase and restarts at slot 0.
        part_d[15:0] = pixel_data_in;
        slot_d       = 3'd1;
        first_d      = 1'b1;
      end else if (state_q == ST_PACK) begin
        if (slot_q == 3'd7) begin
          push    = 1'b1;
          first_d = 1'b0;
        end else begin
          for (int k = 0; k < 7; k++) begin
            if (slot_q == 3'(k)) begin
              part_d[16*k +: 16] = pixel_data_in;
            end
          end
        end
        slot_d = slot_q + 3'd1;
      end
    end
  end

  // Packing datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      run_q   <= 1'b0;
      slot_q  <= 3'd0;
      part_q  <= '0;
      first_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      slot_q  <= slot_d;
      part_q  <= part_d;
      first_q <= first_d;
    end
  end

  assign phrase_axis_valid = (level_q != '0);
  assign phrase_axis_data  = mem_q[rd_ptr_q];
  assign phrase_axis_tuser = mem_tu_q[rd_ptr_q];
  assign buf_level_out     = level_q;

  assign pop   = phrase_axis_valid & phrase_axis_ready;
  assign full  = (level_q == LW'(BUF_DEPTH));
  // With a simultaneous pop the head slot is freed on the same edge, so a
  // full buffer can still accept the new phrase into the slot being vacated.
  assign drop  = push & full & ~pop;
  assign wr_en = push & ~drop;

  // FIFO next state: write at the tail, advance head on pop, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    mem_tu_d = mem_tu_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      mem_d[wr_ptr_q]    = push_data;
      mem_tu_d[wr_ptr_q] = push_tu;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage and pointers; entries are cleared so the outputs read zero
  // during reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i]    <= '0;
        mem_tu_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      mem_tu_q <= mem_tu_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Overflow status: a drop wins over a clear in the same cycle so the event
  // is never lost.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_in) begin
      ovf_d      = drop;
      drop_cnt_d = {15'd0, drop};
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // Overflow status registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow_out   = ovf_q;
  assign drop_count_out = drop_cnt_q;

endmodule

// File: doc/pixel_phrase_builder.md
PIXEL_PHRASE_BUILDER -- requirements
Module: pixel_phrase_builder

Interface
REQ-001 Parameter BUF_DEPTH, default 4, output phrase buffer depth in entries; power of two, minimum 2.
REQ-002 clk_in  input  1  single clock, rising edge.
REQ-003 rst_n_in  input  1  reset; asynchronous assert, active-low.
REQ-004 pixel_data_in  input  16  camera pixel, RGB565.
REQ-005 pixel_valid_in  input  1  pixel_data_in valid this cycle; there is no backpressure toward the camera.
REQ-006 pixel_tuser_in  input  1  qualified by pixel_valid_in; marks the first pixel of a frame.
REQ-007 phrase_axis_data  output  128  packed phrase of 8 pixels.
REQ-008 phrase_axis_tuser  output  1  phrase holds the frame-start pixel.
REQ-009 phrase_axis_valid  output  1  AXIS valid.
REQ-010 phrase_axis_ready  input  1  AXIS ready.
REQ-011 clear_in  input  1  synchronous clear of overflow_out and drop_count_out.
REQ-012 overflow_out  output  1  sticky; set when a completed phrase is dropped.
REQ-013 drop_count_out  output  16  count of dropped phrases, saturating at 16'hFFFF.
REQ-014 buf_level_out  output  $clog2(BUF_DEPTH)+1  current buffer occupancy.

Function
REQ-015 The block SHALL have two states: SYNC (discard pixels) and PACK (accumulate pixels).
REQ-016 SYNC->PACK SHALL occur on a valid pixel with pixel_tuser_in=1; that pixel is stored as slot 0.
REQ-017 In SYNC, valid pixels with pixel_tuser_in=0 SHALL be discarded.
REQ-018 In PACK, a valid pixel SHALL be stored at slot k, bits [16k+15:16k], where k is the 3-bit slot counter; k increments by 1 and wraps from 7 to 0.
REQ-019 A valid pixel with pixel_tuser_in=1 in PACK SHALL discard any partial phrase, be stored as slot 0, and set the phrase's tuser flag.
REQ-020 A phrase SHALL complete on the cycle slot 7 is written; the completed phrase and its tuser flag are pushed into the buffer on that edge.
REQ-021 Latency: when the buffer is empty, phrase_axis_valid SHALL be 1 in the cycle after the slot-7 pixel is sampled.
REQ-022 The buffer SHALL be a first-in first-out queue; the head entry drives phrase_axis_data and phrase_axis_tuser.
REQ-023 A pop SHALL occur when phrase_axis_valid and phrase_axis_ready are both 1.
REQ-024 Once asserted, phrase_axis_valid SHALL stay 1 and phrase_axis_data and phrase_axis_tuser SHALL stay stable until the pop.
REQ-025 A push and a pop in the same cycle SHALL both take effect, including when the buffer is full; buf_level_out is then unchanged.
REQ-026 A push while the buffer is full and no pop occurs SHALL drop the new phrase, set overflow_out, and increment drop_count_out.
REQ-027 Packing SHALL continue normally after a drop; the slot counter is not disturbed.
REQ-028 If clear_in and a drop occur in the same cycle, the result SHALL be overflow_out=1 and drop_count_out=1.
REQ-029 The slot counter SHALL reset to 0 only on a tuser pixel or on reset.

Reset
REQ-030 On rst_n_in=0 the block SHALL immediately (asynchronously) set state=SYNC, slot counter=0, buffer empty, phrase_axis_valid=0, phrase_axis_tuser=0, phrase_axis_data=0, overflow_out=0, drop_count_out=0, buf_level_out=0.
REQ-031 Reset asserted mid-phrase or mid-handshake SHALL discard all partial and buffered data; no phrase is emitted after release until a new tuser pixel is seen.
REQ-032 Reset release SHALL be synchronised internally; the first pixel accepted is the one sampled on the second rising edge after release.

Verification
REQ-033 Send pixels 0x0001..0x0008 with tuser on the first, ready=1 -> one phrase 0x0008_0007_..._0001 with tuser=1, valid 1 cycle after the 8th pixel.
REQ-034 Send 5 pixels without tuser after reset, then a tuser frame of 8 pixels -> exactly one phrase, containing only the tuser frame pixels.
REQ-035 Send 3 pixels after tuser, then a new tuser pixel plus 7 more pixels -> one phrase with tuser=1 that starts at the second tuser pixel.
REQ-036 Hold ready=0 with BUF_DEPTH=4 and send 6 phrases -> buf_level_out=4, drop_count_out=2, overflow_out=1; then ready=1 -> the first 4 phrases emerge in order.
REQ-037 With the buffer full, complete a phrase in the same cycle as a pop -> no drop, buf_level_out stays 4, order preserved.
REQ-038 Pulse rst_n_in low mid-phrase with 2 phrases buffered -> all outputs reset immediately; no stale phrase appears after release.
